// File: rtl/thor2022_tlb_param_if.sv
// Lookup, refill, flush and writeback signals of the parameterised TLB.
// EW is the width of one packed entry {v,g,d,asid,tag,ppn,uperm,sperm}.
interface thor2022_tlb_param_if #(
   parameter int AWID   = 32,
   parameter int ASIDW  = 8,
   parameter int PGBITS = 14,
   parameter int SETS   = 64
);
   localparam int SW   = $clog2(SETS);
   localparam int TAGW = AWID - PGBITS - SW;
   localparam int PPNW = AWID - PGBITS;
   localparam int EW   = 3 + ASIDW + TAGW + PPNW + 8;

   logic             lk_req_i;
   logic [AWID-1:0]  lk_adr_i;
   logic [ASIDW-1:0] lk_asid_i;
   logic             lk_we_i;
   logic             lk_sys_i;
   logic             lk_rdy_o;
   logic             lk_vld_o;
   logic             lk_hit_o;
   logic [AWID-1:0]  lk_padr_o;
   logic [3:0]       lk_acr_o;
   logic             miss_o;
   logic [AWID-1:0]  miss_adr_o;
   logic [ASIDW-1:0] miss_asid_o;
   logic             fill_i;
   logic [EW-1:0]    fill_dat_i;
   logic             fill_rdy_o;
   logic             flush_i;
   logic             flush_all_i;
   logic [ASIDW-1:0] flush_asid_i;
   logic             m_cyc_o;
   logic [EW-1:0]    m_dat_o;
   logic             m_ack_i;
   logic             busy_o;

   modport slave (
      input  lk_req_i, lk_adr_i, lk_asid_i,
      input  lk_we_i, lk_sys_i,
      output lk_rdy_o, lk_vld_o, lk_hit_o,
      output lk_padr_o, lk_acr_o,
      output miss_o, miss_adr_o, miss_asid_o,
      input  fill_i, fill_dat_i,
      output fill_rdy_o,
      input  flush_i, flush_all_i, flush_asid_i,
      output m_cyc_o, m_dat_o,
      input  m_ack_i,
      output busy_o
   );

   modport master (
      output lk_req_i, lk_adr_i, lk_asid_i,
      output lk_we_i, lk_sys_i,
      input  lk_rdy_o, lk_vld_o, lk_hit_o,
      input  lk_padr_o, lk_acr_o,
      input  miss_o, miss_adr_o, miss_asid_o,
      output fill_i, fill_dat_i,
      input  fill_rdy_o,
      output flush_i, flush_all_i, flush_asid_i,
      input  m_cyc_o, m_dat_o,
      output m_ack_i,
      input  busy_o
   );
endinterface

// File: rtl/thor2022_tlb_param.sv
// Set-associative TLB with flop-array storage, miss handoff to a walker,
// ASID flush and a one-entry writeback buffer for dirty evictions.
module thor2022_tlb_param #(
   parameter int WAYS   = 4,
   parameter int SETS   = 64,
   parameter int AWID   = 32,
   parameter int PGBITS = 14,
   parameter int ASIDW  = 8
) (
   input logic clk_i,
   input logic rst_ni,
   thor2022_tlb_param_if.slave bus
);
   localparam int SW     = $clog2(SETS);
   localparam int TAGW   = AWID - PGBITS - SW;
   localparam int PPNW   = AWID - PGBITS;
   localparam int PW     = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int O_UP   = 4;
   localparam int O_PPN  = 8;
   localparam int O_TAG  = O_PPN + PPNW;
   localparam int O_ASID = O_TAG + TAGW;
   localparam int O_D    = O_ASID + ASIDW;
   localparam int O_G    = O_D + 1;
   localparam int O_V    = O_G + 1;
   localparam int EW     = O_V + 1;

   localparam logic [1:0] S_CLR   = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_MISS  = 2'd2;
   localparam logic [1:0] S_FLUSH = 2'd3;

   logic [EW-1:0]    mem [SETS][WAYS];
   logic [PW-1:0]    ptr [SETS];
   logic [1:0]       state;
   logic [SW-1:0]    idx;
   logic             vld_q;
   logic             hit_q;
   logic [AWID-1:0]  padr_q;
   logic [3:0]       acr_q;
   logic             miss_q;
   logic [AWID-1:0]  madr_q;
   logic [ASIDW-1:0] masid_q;
   logic             mcyc_q;
   logic [EW-1:0]    mdat_q;
   logic             fall_q;
   logic [ASIDW-1:0] fasid_q;

   logic [SW-1:0]    lk_set;
   logic [TAGW-1:0]  lk_tag;
   logic             lk_hit;
   logic [PW-1:0]    lk_way;
   logic             accept;
   logic [SW-1:0]    ms;
   logic [PW-1:0]    vw;
   logic             vfree;
   logic [EW-1:0]    vent;
   logic             fill_rdy;
   logic [WAYS-1:0]  fmatch;
   logic             fdirty;
   logic [PW-1:0]    fdw;

   assign lk_set = bus.lk_adr_i[PGBITS +: SW];
   assign lk_tag = bus.lk_adr_i[PGBITS+SW +: TAGW];
   assign ms     = madr_q[PGBITS +: SW];

   assign bus.lk_rdy_o    = (state == S_RUN) & ~bus.flush_i;
   assign accept          = bus.lk_req_i & bus.lk_rdy_o;
   assign bus.lk_vld_o    = vld_q;
   assign bus.lk_hit_o    = hit_q;
   assign bus.lk_padr_o   = padr_q;
   assign bus.lk_acr_o    = acr_q;
   assign bus.miss_o      = miss_q;
   assign bus.miss_adr_o  = madr_q;
   assign bus.miss_asid_o = masid_q;
   assign bus.m_cyc_o     = mcyc_q;
   assign bus.m_dat_o     = mdat_q;
   assign bus.busy_o      = (state != S_RUN);
   assign bus.fill_rdy_o  = fill_rdy;

   // Descending scan so the lowest matching way wins.
   always_comb begin
      lk_hit = 1'b0;
      lk_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (mem[lk_set][w][O_V] &&
             mem[lk_set][w][O_TAG +: TAGW] == lk_tag &&
             (mem[lk_set][w][O_ASID +: ASIDW] == bus.lk_asid_i ||
              mem[lk_set][w][O_G])) begin
            lk_hit = 1'b1;
            lk_way = PW'(w);
         end
      end
   end

   always_comb begin
      vfree = 1'b0;
      vw    = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!mem[ms][w][O_V]) begin
            vfree = 1'b1;
            vw    = PW'(w);
         end
      end
      if (!vfree) vw = ptr[ms];
      vent     = mem[ms][vw];
      fill_rdy = (state == S_MISS) &
                 ~(vent[O_V] & vent[O_D] & mcyc_q);
   end

   always_comb begin
      fmatch = '0;
      fdirty = 1'b0;
      fdw    = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         fmatch[w] = mem[idx][w][O_V] &
                     (fall_q |
                      (mem[idx][w][O_ASID +: ASIDW] == fasid_q &
                       ~mem[idx][w][O_G]));
         if (fmatch[w] && mem[idx][w][O_D]) begin
            fdirty = 1'b1;
            fdw    = PW'(w);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state   <= S_CLR;
         idx     <= '0;
         vld_q   <= 1'b0;
         hit_q   <= 1'b0;
         padr_q  <= '0;
         acr_q   <= '0;
         miss_q  <= 1'b0;
         madr_q  <= '0;
         masid_q <= '0;
         mcyc_q  <= 1'b0;
         mdat_q  <= '0;
         fall_q  <= 1'b0;
         fasid_q <= '0;
      end else begin
         vld_q <= accept;
         if (mcyc_q && bus.m_ack_i) mcyc_q <= 1'b0;
         case (state)
            S_CLR: begin
               for (int w = 0; w < WAYS; w++)
                  mem[idx][w][O_V] <= 1'b0;
               ptr[idx] <= '0;
               idx      <= idx + 1'b1;
               if (idx == SW'(SETS - 1)) state <= S_RUN;
            end
            S_RUN: begin
               if (bus.flush_i) begin
                  state   <= S_FLUSH;
                  idx     <= '0;
                  fall_q  <= bus.flush_all_i;
                  fasid_q <= bus.flush_asid_i;
               end else if (accept && lk_hit) begin
                  hit_q  <= 1'b1;
                  padr_q <= {mem[lk_set][lk_way][O_PPN +: PPNW],
                             bus.lk_adr_i[PGBITS-1:0]};
                  acr_q  <= bus.lk_sys_i ?
                            mem[lk_set][lk_way][3:0] :
                            mem[lk_set][lk_way][O_UP +: 4];
                  if (bus.lk_we_i)
                     mem[lk_set][lk_way][O_D] <= 1'b1;
               end else if (accept) begin
                  hit_q   <= 1'b0;
                  padr_q  <= '0;
                  acr_q   <= '0;
                  miss_q  <= 1'b1;
                  madr_q  <= bus.lk_adr_i;
                  masid_q <= bus.lk_asid_i;
                  state   <= S_MISS;
               end
            end
            S_MISS: begin
               if (bus.fill_i && fill_rdy) begin
                  mem[ms][vw] <= bus.fill_dat_i;
                  if (vent[O_V])
                     ptr[ms] <= (ptr[ms] == PW'(WAYS - 1)) ?
                                '0 : ptr[ms] + 1'b1;
                  if (vent[O_V] && vent[O_D]) begin
                     mcyc_q      <= 1'b1;
                     mdat_q      <= vent;
                     mdat_q[O_D] <= 1'b0;
                  end
                  miss_q <= 1'b0;
                  state  <= S_RUN;
               end
            end
            S_FLUSH: begin
               // Dirty victims leave one at a time through the buffer.
               if (fdirty) begin
                  if (!mcyc_q) begin
                     mem[idx][fdw][O_V] <= 1'b0;
                     mcyc_q             <= 1'b1;
                     mdat_q             <= mem[idx][fdw];
                     mdat_q[O_D]        <= 1'b0;
                  end
               end else begin
                  for (int w = 0; w < WAYS; w++)
                     if (fmatch[w]) mem[idx][w][O_V] <= 1'b0;
                  idx <= idx + 1'b1;
                  if (idx == SW'(SETS - 1)) state <= S_RUN;
               end
            end
            default: state <= S_CLR;
         endcase
      end
   end
endmodule

// File: tb/tb_thor2022_tlb_param.sv
// Randomised bench for thor2022_tlb_param against a set/way reference
// model with lowest-invalid-then-pointer replacement and a writeback queue.
module tb_thor2022_tlb_param;
   localparam int WAYS   = 4;
   localparam int SETS   = 64;
   localparam int AWID   = 32;
   localparam int PGBITS = 14;
   localparam int ASIDW  = 8;
   localparam int SW     = 6;
   localparam int EW     = 49;

   typedef struct {
      bit        v, g, d;
      bit [7:0]  asid;
      bit [11:0] tag;
      bit [17:0] ppn;
      bit [3:0]  up, sp;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   thor2022_tlb_param_if #(
      .AWID(AWID), .ASIDW(ASIDW), .PGBITS(PGBITS), .SETS(SETS)
   ) bus ();

   thor2022_tlb_param #(
      .WAYS(WAYS), .SETS(SETS), .AWID(AWID),
      .PGBITS(PGBITS), .ASIDW(ASIDW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus)
   );

   ent_t      mdl [SETS][WAYS];
   int        mptr [SETS];
   bit [31:0] pend_adr;
   bit [7:0]  pend_asid;
   int        checks = 0;
   int        fails = 0;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [EW-1:0] pack(input ent_t e);
      return {e.v, e.g, e.d, e.asid, e.tag, e.ppn, e.up, e.sp};
   endfunction

   function automatic int set_of(input bit [31:0] a);
      return int'((a >> PGBITS) % SETS);
   endfunction

   function automatic bit [11:0] tag_of(input bit [31:0] a);
      return 12'(a >> (PGBITS + SW));
   endfunction

   function automatic int mhit(input bit [31:0] a, input bit [7:0] asid);
      int s;
      s = set_of(a);
      for (int w = 0; w < WAYS; w++)
         if (mdl[s][w].v && mdl[s][w].tag == tag_of(a) &&
             (mdl[s][w].asid == asid || mdl[s][w].g))
            return w;
      return -1;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < SETS; s++) begin
         mptr[s] = 0;
         for (int w = 0; w < WAYS; w++) mdl[s][w].v = 1'b0;
      end
   endtask

   task automatic do_reset();
      int n;
      @(negedge clk);
      rst_n = 1'b0;
      bus.m_ack_i = 1'b0;
      @(negedge clk);
      check("rst_mcyc", 64'(bus.m_cyc_o), 64'd0);
      check("rst_busy1", 64'(bus.busy_o), 64'd1);
      @(negedge clk);
      check("rst_outs", 64'({bus.lk_rdy_o, bus.lk_vld_o, bus.lk_hit_o,
                             bus.miss_o, bus.fill_rdy_o, bus.m_cyc_o}),
            64'd0);
      check("rst_padr", 64'(bus.lk_padr_o), 64'd0);
      check("rst_acr", 64'(bus.lk_acr_o), 64'd0);
      check("rst_madr", 64'(bus.miss_adr_o), 64'd0);
      check("rst_masid", 64'(bus.miss_asid_o), 64'd0);
      check("rst_mdat", 64'(bus.m_dat_o), 64'd0);
      rst_n = 1'b1;
      model_clear();
      n = 0;
      while (bus.busy_o && n < 500) begin
         n++;
         @(negedge clk);
      end
      check("clr_cycles", 64'(n), 64'd64);
      check("clr_rdy", 64'(bus.lk_rdy_o), 64'd1);
   endtask

   task automatic lookup(input bit [31:0] a, input bit [7:0] asid,
                         input bit we, input bit sys, output bit hit);
      int w, s;
      bit [31:0] pa;
      s = set_of(a);
      w = mhit(a, asid);
      hit = (w >= 0);
      @(negedge clk);
      bus.lk_req_i  = 1'b1;
      bus.lk_adr_i  = a;
      bus.lk_asid_i = asid;
      bus.lk_we_i   = we;
      bus.lk_sys_i  = sys;
      #1;
      check("lk_rdy", 64'(bus.lk_rdy_o), 64'd1);
      @(negedge clk);
      bus.lk_req_i = 1'b0;
      check("lk_vld", 64'(bus.lk_vld_o), 64'd1);
      check("lk_hit", 64'(bus.lk_hit_o), 64'(hit));
      if (hit) begin
         pa = (32'(mdl[s][w].ppn) << PGBITS) |
              (a & ((32'd1 << PGBITS) - 1));
         check("lk_padr", 64'(bus.lk_padr_o), 64'(pa));
         check("lk_acr", 64'(bus.lk_acr_o),
               64'(sys ? mdl[s][w].sp : mdl[s][w].up));
         if (we) mdl[s][w].d = 1'b1;
      end else begin
         check("miss_padr", 64'(bus.lk_padr_o), 64'd0);
         check("miss_acr", 64'(bus.lk_acr_o), 64'd0);
         check("miss_o", 64'(bus.miss_o), 64'd1);
         check("miss_adr", 64'(bus.miss_adr_o), 64'(a));
         check("miss_asid", 64'(bus.miss_asid_o), 64'(asid));
         check("miss_rdy", 64'(bus.lk_rdy_o), 64'd0);
         pend_adr  = a;
         pend_asid = asid;
      end
   endtask

   // hold < 0 leaves a dirty eviction unacknowledged.
   task automatic fill(input ent_t e, input int hold);
      int s, vw;
      ent_t ev;
      s  = set_of(pend_adr);
      vw = -1;
      for (int w = WAYS - 1; w >= 0; w--)
         if (!mdl[s][w].v) vw = w;
      if (vw < 0) vw = mptr[s];
      ev = mdl[s][vw];
      @(negedge clk);
      bus.fill_i     = 1'b1;
      bus.fill_dat_i = pack(e);
      #1;
      check("fill_rdy", 64'(bus.fill_rdy_o), 64'd1);
      @(negedge clk);
      bus.fill_i = 1'b0;
      check("fill_miss", 64'(bus.miss_o), 64'd0);
      check("fill_busy", 64'(bus.busy_o), 64'd0);
      if (ev.v) mptr[s] = (mptr[s] + 1) % WAYS;
      mdl[s][vw] = e;
      if (ev.v && ev.d) begin
         ev.d = 1'b0;
         check("wb_cyc", 64'(bus.m_cyc_o), 64'd1);
         check("wb_dat", 64'(bus.m_dat_o), 64'(pack(ev)));
         if (hold >= 0) begin
            repeat (hold) begin
               @(negedge clk);
               check("wb_hold", 64'(bus.m_cyc_o), 64'd1);
            end
            bus.m_ack_i = 1'b1;
            @(negedge clk);
            bus.m_ack_i = 1'b0;
            check("wb_drop", 64'(bus.m_cyc_o), 64'd0);
         end
      end else begin
         check("no_wb", 64'(bus.m_cyc_o), 64'd0);
      end
   endtask

   task automatic flush(input bit all, input bit [7:0] asid);
      logic [EW-1:0] q[$];
      ent_t e;
      int n, nwb, nexp;
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            e = mdl[s][w];
            if (e.v && (all || (e.asid == asid && !e.g))) begin
               if (e.d) begin
                  e.d = 1'b0;
                  q.push_back(pack(e));
               end
               mdl[s][w].v = 1'b0;
            end
         end
      nexp = q.size();
      @(negedge clk);
      bus.flush_i      = 1'b1;
      bus.flush_all_i  = all;
      bus.flush_asid_i = asid;
      bus.lk_req_i     = 1'b1;
      bus.lk_adr_i     = $urandom;
      #1;
      check("fl_rdy", 64'(bus.lk_rdy_o), 64'd0);
      @(negedge clk);
      bus.flush_i  = 1'b0;
      bus.lk_req_i = 1'b0;
      check("fl_noacc", 64'(bus.lk_vld_o), 64'd0);
      check("fl_busy", 64'(bus.busy_o), 64'd1);
      n = 0;
      nwb = 0;
      while ((bus.busy_o || bus.m_cyc_o) && n < 3000) begin
         if (bus.busy_o) n++;
         if (bus.m_cyc_o && !bus.m_ack_i) begin
            nwb++;
            if (q.size() == 0) check("fl_wb_extra", 64'd1, 64'd0);
            else check("fl_wb_dat", 64'(bus.m_dat_o), 64'(q.pop_front()));
            bus.m_ack_i = 1'b1;
         end else begin
            bus.m_ack_i = 1'b0;
         end
         @(negedge clk);
      end
      bus.m_ack_i = 1'b0;
      check("fl_done", 64'(bus.busy_o), 64'd0);
      check("fl_wb_cnt", 64'(nwb), 64'(nexp));
      if (nexp == 0) check("fl_cycles", 64'(n), 64'd64);
   endtask

   function automatic ent_t mk(input bit [31:0] a, input bit [7:0] asid,
                               input bit g, input bit d);
      ent_t e;
      e.v = 1'b1; e.g = g; e.d = d; e.asid = asid;
      e.tag = tag_of(a);
      e.ppn = 18'($urandom);
      e.up = 4'($urandom);
      e.sp = 4'($urandom);
      return e;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      bit h;
      ent_t e;
      bit [31:0] a, b;
      bus.lk_req_i = 1'b0; bus.lk_adr_i = '0; bus.lk_asid_i = '0;
      bus.lk_we_i = 1'b0; bus.lk_sys_i = 1'b0; bus.fill_i = 1'b0;
      bus.fill_dat_i = '0; bus.flush_i = 1'b0; bus.flush_all_i = 1'b0;
      bus.flush_asid_i = '0; bus.m_ack_i = 1'b0;

      do_reset();
      lookup(32'h0001_2345, 8'd1, 1'b0, 1'b0, h);
      e = mk(32'h0001_2345, 8'd1, 1'b0, 1'b0);
      e.ppn = 18'h3ABCD; e.up = 4'hF; e.sp = 4'h0;
      fill(e, 0);
      lookup(32'h0001_2345, 8'd1, 1'b0, 1'b0, h);
      check("ex_padr", 64'(bus.lk_padr_o), 64'hEAF3_6345);
      check("ex_acr", 64'(bus.lk_acr_o), 64'hF);
      lookup(32'h0001_2345, 8'd1, 1'b1, 1'b1, h);
      for (int t = 1; t <= 4; t++) begin
         a = (32'(t) << 20) | (32'd4 << 14) | 32'h100;
         lookup(a, 8'd1, 1'b0, 1'b0, h);
         fill(mk(a, 8'd1, 1'b0, 1'b0), 3);
      end

      a = (32'h7 << 20) | (32'd10 << 14);
      b = (32'h8 << 20) | (32'd10 << 14);
      lookup(a, 8'd3, 1'b0, 1'b0, h);
      fill(mk(a, 8'd5, 1'b1, 1'b0), 0);
      lookup(b, 8'd3, 1'b0, 1'b0, h);
      fill(mk(b, 8'd3, 1'b0, 1'b0), 0);
      flush(1'b0, 8'd3);
      lookup(a, 8'd3, 1'b0, 1'b0, h);
      check("gl_hit", 64'(h), 64'd1);
      lookup(b, 8'd3, 1'b0, 1'b0, h);
      check("as_miss", 64'(h), 64'd0);
      fill(mk(b, 8'd3, 1'b0, 1'b0), 0);

      @(negedge clk);
      bus.fill_i = 1'b1;
      bus.fill_dat_i = pack(mk(32'h0000_0000, 8'd1, 1'b1, 1'b1));
      #1;
      check("fill_idle_rdy", 64'(bus.fill_rdy_o), 64'd0);
      @(negedge clk);
      bus.fill_i = 1'b0;

      for (int i = 0; i < 300; i++) begin
         int sel, st;
         bit [7:0] as;
         sel = $urandom_range(0, 19);
         if (sel == 0) begin
            flush($urandom_range(0, 3) == 0, 8'($urandom_range(1, 3)));
         end else begin
            case ($urandom_range(0, 3))
               0: st = 1;
               1: st = 2;
               2: st = 7;
               default: st = 63;
            endcase
            a = (32'($urandom_range(0, 5)) << 20) | (32'(st) << 14) |
                32'($urandom_range(0, 16383));
            as = 8'($urandom_range(1, 3));
            lookup(a, as, 1'($urandom), 1'($urandom), h);
            if (!h)
               fill(mk(a, as, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 2) == 0), $urandom_range(0, 2));
         end
      end

      for (int t = 0; t < 5; t++) begin
         a = (32'(t) << 20) | (32'd20 << 14);
         lookup(a, 8'd2, 1'b0, 1'b0, h);
         if (!h) fill(mk(a, 8'd2, 1'b0, 1'b1), -1);
      end
      check("abort_cyc", 64'(bus.m_cyc_o), 64'd1);
      do_reset();
      lookup(32'h0001_2345, 8'd1, 1'b0, 1'b0, h);
      check("post_rst_miss", 64'(h), 64'd0);
      fill(mk(32'h0001_2345, 8'd1, 1'b0, 1'b0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/thor2022_tlb_param.md
THOR2022_TLB_PARAM -- requirements
Module: thor2022_tlb_param

Interface
REQ-001 SHALL have parameter WAYS, default 4, ways per set (1..16).
REQ-002 SHALL have parameter SETS, default 64, sets (power of two, >=2).
REQ-003 SHALL have parameter AWID, default 32, virtual/physical address width.
REQ-004 SHALL have parameter PGBITS, default 14, page-offset bits; set index = adr[PGBITS+log2(SETS)-1:PGBITS]; tag = remaining upper bits.
REQ-005 SHALL have parameter ASIDW, default 8, ASID width.
REQ-006 Entry fields: v, g, d, asid[ASIDW], tag, ppn[AWID-PGBITS], uperm[3:0] (c,r,w,x), sperm[3:0] (sc,sr,sw,sx).
REQ-007 Ports (clock and reset first):
 clk_i  in  1  sole clock, rising edge
 rst_ni  in  1  reset, synchronous, active-low
 lk_req_i  in  1  lookup request
 lk_adr_i  in  AWID  virtual address
 lk_asid_i  in  ASIDW  current ASID
 lk_we_i  in  1  lookup is a store
 lk_sys_i  in  1  system-mode access
 lk_rdy_o  out  1  lookup accepted this cycle
 lk_vld_o  out  1  lookup result valid
 lk_hit_o  out  1  lookup hit
 lk_padr_o  out  AWID  physical address
 lk_acr_o  out  4  access rights
 miss_o  out  1  miss pending to walker
 miss_adr_o  out  AWID  missing virtual address
 miss_asid_o  out  ASIDW  missing ASID
 fill_i  in  1  refill strobe
 fill_dat_i  in  entry  refill entry
 fill_rdy_o  out  1  refill accepted
 flush_i  in  1  start flush
 flush_all_i  in  1  flush ignores ASID/g
 flush_asid_i  in  ASIDW  ASID to flush
 m_cyc_o  out  1  dirty writeback cycle
 m_dat_o  out  entry  entry written back
 m_ack_i  in  1  writeback acknowledge
 busy_o  out  1  clear/flush/miss in progress

Function
REQ-008 States CLR, RUN, MISS, FLUSH; flop-array entry storage.
REQ-009 CLR: one set per cycle, index 0..SETS-1, all ways v=0, per-set replacement pointer=0; SETS cycles then RUN.
REQ-010 lk_rdy_o = (state==RUN) & ~flush_i; lookup accepted when lk_req_i & lk_rdy_o.
REQ-011 Result exactly 1 cycle after acceptance: lk_vld_o high for one cycle.
REQ-012 Hit: v & tag match & (asid==lk_asid_i | g); multiple matches -> lowest way.
REQ-013 On hit: lk_padr_o = {ppn, adr[PGBITS-1:0]}; lk_acr_o = lk_sys_i ? sperm : uperm; lk_hit_o=1.
REQ-014 Store hit with d=0 sets d in same cycle as lk_vld_o.
REQ-015 Miss: lk_hit_o=0, lk_acr_o=0, lk_padr_o=0; miss_o, miss_adr_o, miss_asid_o registered same cycle; state MISS; lk_rdy_o low.
REQ-016 MISS: fill_rdy_o = ~(victim valid & d & m_cyc_o); fill_i & fill_rdy_o writes fill_dat_i to victim, clears miss_o, returns RUN next cycle.
REQ-017 Victim: lowest invalid way in set, else way at set pointer; pointer increments mod WAYS on each replacement of a valid way.
REQ-018 Evicted valid dirty entry: m_cyc_o=1, m_dat_o=entry with d=0, held until m_ack_i; m_cyc_o drops cycle after m_ack_i; one-entry buffer.
REQ-019 fill_i outside MISS ignored; m_ack_i without m_cyc_o ignored.
REQ-020 flush_i in RUN has priority over lk_req_i; FLUSH walks sets 0..SETS-1, one per cycle, invalidating entries with flush_all_i | (asid==flush_asid_i & ~g).
REQ-021 Dirty entry invalidated during FLUSH goes to writeback buffer; walk stalls on that set while buffer occupied; multiple dirty ways in one set drained lowest-first.
REQ-022 flush_i during CLR, MISS, FLUSH ignored.
REQ-023 busy_o = state!=RUN.
REQ-024 Address/pointer arithmetic wraps modulo field width; no carry into tag.

Reset
REQ-025 rst_ni low at a clock edge: state CLR, all outputs 0 (lk_rdy_o, lk_vld_o, lk_hit_o, lk_padr_o, lk_acr_o, miss_o, miss_adr_o, miss_asid_o, fill_rdy_o, m_cyc_o, m_dat_o), busy_o=1.
REQ-026 Reset mid-operation abandons pending miss/writeback (no further m_cyc_o) and restarts CLR from set 0.

Verification
REQ-027 Reset, WAYS=4,SETS=64 -> busy_o high 64 cycles, then lk_rdy_o=1; lookup 0x0001_2345 -> lk_vld_o, lk_hit_o=0, miss_o, miss_adr_o=0x0001_2345.
REQ-028 Fill ppn=0x3ABCD, uperm=4'hF; user lookup 0x0001_2345 -> hit, lk_padr_o=0xEAF3_6345, lk_acr_o=4'hF one cycle later.
REQ-029 Fill 5 distinct tags same set, first stored via store hit (d=1) -> 5th fill evicts way 0, m_cyc_o with m_dat_o.d=0 until m_ack_i.
REQ-030 Flush ASID 3 with one global and one ASID-3 entry -> global still hits, ASID-3 misses; flush takes SETS cycles with no dirty entries.
REQ-031 flush_i and lk_req_i same cycle -> lk_rdy_o=0, lookup not accepted, FLUSH entered.
REQ-032 rst_ni low while m_cyc_o=1 -> m_cyc_o=0 next cycle, CLR restarts.
